// File: rtl/tlul_timer.sv
// tlul_timer: TL-UL timer peripheral in a 1 kB device slot.
// Prescaled 64-bit free-running mtime, 64-bit mtimecmp, level interrupt.
// Single outstanding request, registered response one cycle after acceptance.
//
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset
//   tl_i   - TL-UL request channel (tlul_pkg::tl_h2d_t)
//   tl_o   - TL-UL response channel (tlul_pkg::tl_d2h_t)
//   irq_o  - registered level timer interrupt
//
// Optional build macro TLUL_TIMER_SNAPSHOT_EN: a read of MTIME_LO latches
// mtime[63:32] into a shadow returned by MTIME_HI reads (coherent LO/HI pair).
// PrescW must not exceed 32.

package tlul_pkg;
    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

module tlul_timer #(
    parameter int          PrescW      = 16,
    parameter logic [63:0] CmpResetVal = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  tlul_pkg::tl_h2d_t tl_i,
    output tlul_pkg::tl_d2h_t tl_o,
    output logic              irq_o
);
    localparam logic [9:0] OffCtrl   = 10'h000;
    localparam logic [9:0] OffPresc  = 10'h004;
    localparam logic [9:0] OffMtLo   = 10'h008;
    localparam logic [9:0] OffMtHi   = 10'h00C;
    localparam logic [9:0] OffCmpLo  = 10'h010;
    localparam logic [9:0] OffCmpHi  = 10'h014;
    localparam logic [9:0] OffStatus = 10'h018;

    logic              en_q, irq_en_q, irq_q;
    logic [PrescW-1:0] presc_q, pcnt_q;
    logic [63:0]       mtime_q, cmp_q;
    logic              d_valid_q, d_error_q;
    logic [2:0]        d_opcode_q;
    logic [1:0]        d_size_q;
    logic [7:0]        d_source_q;
    logic [31:0]       d_data_q;
`ifdef TLUL_TIMER_SNAPSHOT_EN
    logic [31:0]       shadow_q;
`endif

    logic [9:0]  offset;
    logic        accept, is_get, is_put, addr_hit, bad, wr_en, rd_en, tick, cmp_hit;
    logic [31:0] rdata;
    logic        unused_tl;

    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
        end
        return res;
    endfunction

    assign unused_tl = ^{tl_i.a_param, tl_i.a_address[31:10]};

    assign offset  = tl_i.a_address[9:0];
    assign accept  = tl_i.a_valid & ~d_valid_q;
    assign is_get  = (tl_i.a_opcode == tlul_pkg::Get);
    assign is_put  = (tl_i.a_opcode == tlul_pkg::PutFullData) |
                     (tl_i.a_opcode == tlul_pkg::PutPartialData);
    assign bad     = ~(is_get | is_put) | (tl_i.a_address[1:0] != 2'b00) | ~addr_hit;
    assign wr_en   = accept & is_put & ~bad;
    assign rd_en   = accept & is_get & ~bad;
    assign tick    = en_q & (pcnt_q == presc_q);
    assign cmp_hit = (mtime_q >= cmp_q);

    always_comb begin
        addr_hit = 1'b0;
        case (offset)
            OffCtrl, OffPresc, OffMtLo, OffMtHi,
            OffCmpLo, OffCmpHi, OffStatus: addr_hit = 1'b1;
            default:                       addr_hit = 1'b0;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (offset)
            OffCtrl:   rdata = {30'b0, irq_en_q, en_q};
            OffPresc:  rdata = 32'(presc_q);
            OffMtLo:   rdata = mtime_q[31:0];
`ifdef TLUL_TIMER_SNAPSHOT_EN
            OffMtHi:   rdata = shadow_q;
`else
            OffMtHi:   rdata = mtime_q[63:32];
`endif
            OffCmpLo:  rdata = cmp_q[31:0];
            OffCmpHi:  rdata = cmp_q[63:32];
            OffStatus: rdata = {31'b0, cmp_hit};
            default:   rdata = '0;
        endcase
    end

    // Control registers and compare value
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            presc_q  <= '0;
            cmp_q    <= CmpResetVal;
            irq_q    <= 1'b0;
        end else begin
            if (wr_en && offset == OffCtrl && tl_i.a_mask[0]) begin
                en_q     <= tl_i.a_data[0];
                irq_en_q <= tl_i.a_data[1];
            end
            if (wr_en && offset == OffPresc)
                presc_q <= PrescW'(merge_bytes(32'(presc_q), tl_i.a_data, tl_i.a_mask));
            if (wr_en && offset == OffCmpLo)
                cmp_q[31:0] <= merge_bytes(cmp_q[31:0], tl_i.a_data, tl_i.a_mask);
            if (wr_en && offset == OffCmpHi)
                cmp_q[63:32] <= merge_bytes(cmp_q[63:32], tl_i.a_data, tl_i.a_mask);
            // Compare uses current register values, so writes show up one cycle later.
            irq_q <= irq_en_q & cmp_hit;
        end
    end

    // Prescaler and mtime; a bus write to either mtime half swallows that cycle's tick.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcnt_q  <= '0;
            mtime_q <= '0;
        end else begin
            if (wr_en && offset == OffPresc)
                pcnt_q <= '0;
            else if (en_q)
                pcnt_q <= tick ? '0 : pcnt_q + PrescW'(1);

            if (wr_en && offset == OffMtLo)
                mtime_q[31:0] <= merge_bytes(mtime_q[31:0], tl_i.a_data, tl_i.a_mask);
            else if (wr_en && offset == OffMtHi)
                mtime_q[63:32] <= merge_bytes(mtime_q[63:32], tl_i.a_data, tl_i.a_mask);
            else if (tick)
                mtime_q <= mtime_q + 64'd1;
        end
    end

`ifdef TLUL_TIMER_SNAPSHOT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)
            shadow_q <= '0;
        else if (rd_en && offset == OffMtLo)
            shadow_q <= mtime_q[63:32];
        else if (wr_en && offset == OffMtHi)
            shadow_q <= merge_bytes(mtime_q[63:32], tl_i.a_data, tl_i.a_mask);
    end
`endif

    // Response channel: valid is the only reset state; payload is captured on accept.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            d_valid_q <= 1'b0;
        else if (accept)
            d_valid_q <= 1'b1;
        else if (tl_i.d_ready)
            d_valid_q <= 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            d_opcode_q <= is_get ? tlul_pkg::AccessAckData : tlul_pkg::AccessAck;
            d_size_q   <= tl_i.a_size;
            d_source_q <= tl_i.a_source;
            d_data_q   <= rd_en ? rdata : 32'h0;
            d_error_q  <= bad;
        end
    end

    always_comb begin
        tl_o          = '0;
        tl_o.d_valid  = d_valid_q;
        tl_o.d_opcode = d_opcode_q;
        tl_o.d_param  = 3'h0;
        tl_o.d_size   = d_size_q;
        tl_o.d_source = d_source_q;
        tl_o.d_sink   = 1'b0;
        tl_o.d_data   = d_data_q;
        tl_o.d_error  = d_error_q;
        tl_o.a_ready  = ~d_valid_q;
    end

    assign irq_o = irq_q;
endmodule

// File: tb/tb_tlul_timer.sv
// tb_tlul_timer: randomized and directed bench for tlul_timer against a
// behavioural register/timebase model kept in the bench.
module tb_tlul_timer;
    localparam logic [2:0]  OpGet  = 3'h4;
    localparam logic [2:0]  OpPutF = 3'h0;
    localparam logic [2:0]  OpPutP = 3'h1;
    localparam logic [31:0] Base   = 32'hC000_0400;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    tlul_pkg::tl_h2d_t tl_i;
    tlul_pkg::tl_d2h_t tl_o;
    logic              irq_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    bit          m_en, m_irq_en, m_irq, m_dvalid, m_err;
    int unsigned m_presc, m_pcnt;
    logic [63:0] m_mtime, m_cmp;
    logic [31:0] m_shadow, m_rdata;
    logic [2:0]  m_op;
    logic [7:0]  m_src;
    logic [1:0]  m_size;

    tlul_timer dut (.clk_i(clk), .rst_i(rst), .tl_i(tl_i), .tl_o(tl_o), .irq_o(irq_o));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = cur;
        for (int i = 0; i < 4; i++) if (m[i]) r[i*8 +: 8] = wd[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [9:0] off);
        case (off)
            10'h000: return {30'b0, m_irq_en, m_en};
            10'h004: return m_presc;
            10'h008: return m_mtime[31:0];
`ifdef TLUL_TIMER_SNAPSHOT_EN
            10'h00C: return m_shadow;
`else
            10'h00C: return m_mtime[63:32];
`endif
            10'h010: return m_cmp[31:0];
            10'h014: return m_cmp[63:32];
            10'h018: return {31'b0, m_mtime >= m_cmp};
            default: return 32'h0;
        endcase
    endfunction

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic [63:0] mt_old;
        logic [9:0]  off;
        logic [2:0]  op;
        bit          acc, err, known, irq_nx;
        int unsigned n;
        if (rst) begin
            m_en = 0; m_irq_en = 0; m_presc = 0; m_pcnt = 0; m_mtime = '0;
            m_cmp = '1; m_shadow = '0; m_irq = 0; m_dvalid = 0;
            return;
        end
        mt_old = m_mtime;
        irq_nx = m_irq_en && (m_mtime >= m_cmp);
        acc    = tl_i.a_valid && !m_dvalid;
        off    = tl_i.a_address[9:0];
        op     = tl_i.a_opcode;
        known  = off inside {10'h000, 10'h004, 10'h008, 10'h00C, 10'h010, 10'h014, 10'h018};
        err    = !(op inside {OpGet, OpPutF, OpPutP}) || (tl_i.a_address[1:0] != 2'b00) || !known;
        if (acc) begin
            m_dvalid = 1;
            m_err    = err;
            m_op     = (op == OpGet) ? 3'h1 : 3'h0;
            m_src    = tl_i.a_source;
            m_size   = tl_i.a_size;
            m_rdata  = (!err && op == OpGet) ? model_read(off) : 32'h0;
        end else if (m_dvalid && tl_i.d_ready) begin
            m_dvalid = 0;
        end
        if (m_en) begin
            n       = m_pcnt + 1;
            m_mtime = m_mtime + 64'(n / (m_presc + 1));
            m_pcnt  = n % (m_presc + 1);
        end
        if (acc && !err && op == OpGet && off == 10'h008) m_shadow = mt_old[63:32];
        if (acc && !err && op != OpGet) begin
            case (off)
                10'h000: if (tl_i.a_mask[0]) begin
                    m_en = tl_i.a_data[0]; m_irq_en = tl_i.a_data[1];
                end
                10'h004: begin
                    m_presc = merge(m_presc, tl_i.a_data, tl_i.a_mask) & 32'hFFFF;
                    m_pcnt  = 0;
                end
                10'h008: m_mtime = {mt_old[63:32], merge(mt_old[31:0], tl_i.a_data, tl_i.a_mask)};
                10'h00C: begin
                    m_mtime  = {merge(mt_old[63:32], tl_i.a_data, tl_i.a_mask), mt_old[31:0]};
                    m_shadow = m_mtime[63:32];
                end
                10'h010: m_cmp[31:0]  = merge(m_cmp[31:0], tl_i.a_data, tl_i.a_mask);
                10'h014: m_cmp[63:32] = merge(m_cmp[63:32], tl_i.a_data, tl_i.a_mask);
                default: ;
            endcase
        end
        m_irq = irq_nx;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("irq_o", irq_o, m_irq);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic access(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] mask, output logic [31:0] rd, output logic er);
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = op;
        tl_i.a_address = addr;
        tl_i.a_data    = data;
        tl_i.a_mask    = mask;
        tl_i.a_size    = 2'd2;
        tl_i.a_source  = 8'($urandom);
        tl_i.d_ready   = 1'b1;
        check("a_ready", tl_o.a_ready, !m_dvalid);
        cycle();
        tl_i.a_valid = 1'b0;
        check("d_valid", tl_o.d_valid, m_dvalid);
        check("d_data", tl_o.d_data, m_rdata);
        check("d_error", tl_o.d_error, m_err);
        check("d_opcode", tl_o.d_opcode, m_op);
        check("d_source", tl_o.d_source, m_src);
        check("d_size", tl_o.d_size, m_size);
        rd = tl_o.d_data;
        er = tl_o.d_error;
        cycle();
    endtask

    initial begin
        logic [31:0] rd, v0, addr, data;
        logic [3:0]  mask;
        logic [2:0]  op;
        logic        er;
        logic [9:0]  offs [10];
        offs = '{10'h000, 10'h004, 10'h008, 10'h00C, 10'h010, 10'h014, 10'h018,
                 10'h01C, 10'h3FC, 10'h002};

        tl_i = '0;
        rst  = 1'b1;
        cycle();
        check("rst_d_valid", tl_o.d_valid, 0);
        check("rst_a_ready", tl_o.a_ready, 1);
        check("rst_irq", irq_o, 0);
        cycle();
        rst = 1'b0;

        access(OpGet, Base + 32'h10, 0, 4'hF, rd, er);
        check("cmp_lo_rst", rd, 32'hFFFF_FFFF);
        check("cmp_lo_err", er, 0);
        access(OpGet, Base + 32'h14, 0, 4'hF, rd, er);
        check("cmp_hi_rst", rd, 32'hFFFF_FFFF);
        access(OpGet, Base + 32'h08, 0, 4'hF, rd, er);
        check("mtime_rst", rd, 0);

        access(OpPutF, Base + 32'h04, 3, 4'hF, rd, er);
        access(OpPutF, Base + 32'h00, 1, 4'hF, rd, er);
        idle(40);
        access(OpGet, Base + 32'h08, 0, 4'hF, rd, er);
        check("mtime_presc3", (rd >= 9 && rd <= 11), 1);

        access(OpPutF, Base + 32'h00, 0, 4'hF, rd, er);
        access(OpPutF, Base + 32'h0C, 32'hFFFF_FFFF, 4'hF, rd, er);
        access(OpPutF, Base + 32'h08, 32'hFFFF_FFFF, 4'hF, rd, er);
        access(OpPutF, Base + 32'h04, 0, 4'hF, rd, er);
        access(OpGet, Base + 32'h18, 0, 4'hF, rd, er);
        check("status_full", rd, 1);
        access(OpPutF, Base + 32'h00, 1, 4'hF, rd, er);
        access(OpGet, Base + 32'h08, 0, 4'hF, rd, er);
        access(OpGet, Base + 32'h0C, 0, 4'hF, rd, er);
        check("wrap_hi", rd, 0);

        access(OpPutF, Base + 32'h00, 0, 4'hF, rd, er);
        access(OpPutF, Base + 32'h08, 0, 4'hF, rd, er);
        access(OpPutF, Base + 32'h0C, 0, 4'hF, rd, er);
        access(OpPutF, Base + 32'h14, 0, 4'hF, rd, er);
        access(OpPutF, Base + 32'h10, 5, 4'hF, rd, er);
        access(OpPutF, Base + 32'h00, 3, 4'hF, rd, er);
        idle(8);
        check("irq_high", irq_o, 1);
        access(OpPutF, Base + 32'h14, 1, 4'hF, rd, er);
        check("irq_drop", irq_o, 0);

        access(OpPutF, Base + 32'h00, 0, 4'hF, rd, er);
        access(OpGet, Base + 32'h1C, 0, 4'hF, rd, er);
        check("bad_off_err", er, 1);
        check("bad_off_data", rd, 0);
        access(OpGet, Base + 32'h02, 0, 4'hF, rd, er);
        check("misalign_err", er, 1);
        access(3'h5, Base + 32'h00, 3, 4'hF, rd, er);
        check("bad_op_err", er, 1);
        access(OpGet, Base + 32'h00, 0, 4'hF, rd, er);
        check("ctrl_unchanged", rd, 0);
        access(OpPutP, Base + 32'h04, 32'hABCD, 4'b0001, rd, er);
        access(OpGet, Base + 32'h04, 0, 4'hF, rd, er);
        check("presc_partial", rd, 32'hCD);

        // Stalled response, with a competing request that must not be taken
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = OpGet;
        tl_i.a_address = Base + 32'h08;
        tl_i.d_ready   = 1'b0;
        cycle();
        tl_i.a_address = Base + 32'h10;
        check("stall_d_valid0", tl_o.d_valid, 1);
        v0 = tl_o.d_data;
        check("stall_data0", v0, m_rdata);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("stall_d_valid", tl_o.d_valid, 1);
            check("stall_d_data", tl_o.d_data, v0);
            check("stall_a_ready", tl_o.a_ready, 0);
        end
        tl_i.a_valid = 1'b0;
        rst = 1'b1;
        cycle();
        check("midrst_d_valid", tl_o.d_valid, 0);
        check("midrst_a_ready", tl_o.a_ready, 1);
        rst = 1'b0;
        access(OpGet, Base + 32'h10, 0, 4'hF, rd, er);
        check("midrst_cmp", rd, 32'hFFFF_FFFF);

        // LO read just before a carry into HI, then HI read
        access(OpPutF, Base + 32'h04, 0, 4'hF, rd, er);
        access(OpPutF, Base + 32'h0C, 7, 4'hF, rd, er);
        access(OpPutF, Base + 32'h08, 32'hFFFF_FFFD, 4'hF, rd, er);
        access(OpPutF, Base + 32'h00, 1, 4'hF, rd, er);
        access(OpGet, Base + 32'h08, 0, 4'hF, rd, er);
        check("carry_lo", rd, 32'hFFFF_FFFE);
        access(OpGet, Base + 32'h0C, 0, 4'hF, rd, er);
`ifdef TLUL_TIMER_SNAPSHOT_EN
        check("snap_hi", rd, 7);
`else
        check("live_hi", rd, 8);
`endif

        for (int t = 0; t < 250; t++) begin
            idle($urandom_range(0, 2));
            case ($urandom_range(0, 9))
                0, 1, 2, 3: op = OpGet;
                4, 5, 6:    op = OpPutF;
                7, 8:       op = OpPutP;
                default:    op = 3'($urandom_range(5, 7));
            endcase
            addr = Base | 32'(offs[$urandom_range(0, 9)]);
            data = $urandom;
            if (addr[9:0] == 10'h004) data = $urandom_range(0, 3);
            if (addr[9:0] == 10'h00C || addr[9:0] == 10'h014) data = $urandom_range(0, 1);
            mask = (op == OpPutF) ? 4'hF : 4'($urandom);
            access(op, addr, data, mask, rd, er);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tlul_timer.md
Name: tlul_timer

Overview:
- TL-UL peripheral occupying one 1 kB device slot behind the crossbar's 1:N socket, starting at 0xC0000000 + k*0x400.
- Provides a prescaled 64-bit free-running mtime counter, a 64-bit mtimecmp compare register and a level timer interrupt.
- Single-outstanding TL-UL device: one response per accepted request, 1-cycle latency, explicit d_error on bad accesses.

Parameters:
- PrescW, 16, width of the prescaler limit register and prescaler counter.
- CmpResetVal, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, synchronous, active-high.
- tl_i  input  tlul_pkg::tl_h2d_t  request channel from the crossbar.
- tl_o  output  tlul_pkg::tl_d2h_t  response channel to the crossbar.
- irq_o  output  1  timer interrupt, level, registered.

Behaviour:
- Register map, offset = a_address[9:0]:
  - 0x00 CTRL: [0] enable, [1] irq_en; other bits RAZ/WI.
  - 0x04 PRESCALE: [PrescW-1:0].
  - 0x08 MTIME_LO, 0x0C MTIME_HI.
  - 0x10 MTIMECMP_LO, 0x14 MTIMECMP_HI.
  - 0x18 STATUS: [0] = mtime >= mtimecmp; read-only, writes ignored without error.
- Reset values (first edge with rst_i=1):
  - tl_o.d_valid=0, tl_o.a_ready=1, irq_o=0.
  - CTRL=0, PRESCALE=0, prescaler counter=0, mtime=0, mtimecmp=CmpResetVal.
- Handshake:
  - a_ready = ~d_valid_q. A request is accepted when a_valid & a_ready.
  - Response registered: d_valid rises the cycle after acceptance and holds with stable fields until d_ready.
  - At most one request outstanding, so back-to-back throughput is one request per 2 cycles when d_ready is held high.
- Response fields:
  - d_opcode = AccessAckData for Get, AccessAck otherwise.
  - d_source and d_size echo the request; d_sink=0.
  - d_data = read value for a good Get, 0 otherwise.
- Errors (d_error=1, no register updated, read data 0):
  - opcode not in {Get, PutFullData, PutPartialData};
  - a_address[1:0] != 0;
  - offset not in the map.
- Writes honour a_mask byte enables. PutPartialData with mask=0 is a legal no-op.
- Prescaler and counter:
  - When CTRL.enable=1, the prescaler counts 0..PRESCALE. On reaching PRESCALE it returns to 0 and mtime increments by 1.
  - PRESCALE=0 gives one tick per cycle.
  - When enable=0, prescaler and mtime hold.
  - mtime wraps from 2^64-1 to 0 silently.
- Simultaneous events:
  - A bus write to MTIME_LO/HI in the same cycle as a tick: the write wins and the tick is lost. Only the written half changes; the other half keeps its pre-tick value.
  - A write to PRESCALE clears the prescaler counter.
- irq_o is registered: irq_o <= irq_en & (mtime >= mtimecmp), compared on current register values. It follows mtimecmp writes with 1 cycle of latency.
- Reset mid-transaction: a pending response is discarded (d_valid=0 after the reset edge), and all state returns to reset values.

Optional Feature:
- Macro TLUL_TIMER_SNAPSHOT_EN.
- Defined:
  - A good read of MTIME_LO copies mtime[63:32] into a shadow register in the same cycle the read value is captured.
  - Reads of MTIME_HI return the shadow, giving coherent 64-bit reads (LO then HI). The shadow resets to 0.
  - Writes to MTIME_HI update both mtime and the shadow.
- Undefined: MTIME_HI returns live mtime[63:32]; no shadow register exists.

Test Plan:
- Reset, then Get 0x10 and 0x14 → d_data 0xFFFFFFFF twice, d_error=0, d_opcode=AccessAckData, irq_o=0; Get 0x08 → 0.
- PRESCALE=3, CTRL=1, wait 40 cycles after the enable write completes → MTIME_LO reads 10 (±1 for access timing; check the exact value against the model).
- mtime=0xFFFFFFFF_FFFFFFFF (HI then LO written with enable=0), PRESCALE=0, CTRL=1 → next read of MTIME_LO/HI shows the wrapped value; STATUS[0] is 1 before the wrap.
- mtimecmp=5, CTRL=3, PRESCALE=0 → irq_o rises exactly one cycle after mtime reaches 5; writing MTIMECMP_HI=1 drops irq_o one cycle later.
- Get 0x1C, Get 0x02, and opcode 3'h5 to 0x00 → d_error=1, d_data=0, registers unchanged; PutPartialData to 0x04 with mask=4'b0001, data 0xABCD → PRESCALE=0xCD.
- Hold d_ready=0 for 5 cycles after a Get → d_valid and d_data stable, a_ready=0 throughout. Assert rst_i during the stall → d_valid=0 and a_ready=1 on the next cycle. With TLUL_TIMER_SNAPSHOT_EN: read LO while a carry into HI occurs, then read HI → HI equals the value at the LO read.
